quad_core_fetch_mem: RTL and testbench
======================================

Name: quad_core_fetch_mem

Overview:
- Shared fetch/memory subsystem for the 4-core bit-serial processor.
- Contains four 16-bit program counters, a 4-read-port instruction memory and a 4-port 1-bit data RAM.
- Each core reads its instruction and data bit combinationally, then branches, returns or stores on the clock edge.
- Sits between the per-core execute units (which supply accumulator bit and stack value) and the program loader.

Parameters:
- PC_INIT0, 16'h0000, reset PC of core 0
- PC_INIT1, 16'h0003, reset PC of core 1
- PC_INIT2, 16'h0006, reset PC of core 2
- PC_INIT3, 16'h0009, reset PC of core 3
- IMEM_DEPTH, 256, instruction words (power of 2)
- BRAM_DEPTH, 64, data bits (power of 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- prog_we  in  1  instruction-memory write enable
- prog_addr  in  16  instruction write address
- prog_data  in  16  instruction write data
- imem_clear  in  1  synchronous clear of the instruction memory
- bram_clear  in  1  synchronous clear of the data RAM
- acc_bit  in  4  accumulator bit per core (bit i = core i)
- stack_in  in  64  return address per core, core i at [16i+15:16i]
- pc  out  64  program counter per core
- instr  out  64  fetched instruction per core
- bit_data  out  4  data-RAM read bit per core
- addr_cond  out  68  per core {bit_data, 2'b00, instr[13:0]}, core i at [17i+16:17i]

Behaviour:
- Instruction fields:
  - bit15 = STORE
  - bit14 = LOAD_PC
  - bits13:0 = operand address
  - bits 15 and 14 both set = RETURN
- Reset asserted (low):
  - pc_i forced to PC_INITi immediately.
  - All data-RAM bits cleared to 0.
  - Instruction memory is not affected.
- Instruction fetch:
  - instr_i = imem[pc_i], combinational.
  - pc_i >= IMEM_DEPTH reads 16'h0000.
- Data read:
  - bit_data_i = bram[instr_i[13:0] mod BRAM_DEPTH], combinational.
- addr_cond_i is combinational: bit16 = bit_data_i, bits15:14 = 0, bits13:0 = instr_i[13:0].
- PC update, each rising edge while reset is high:
  - instr[14]=1 and instr[15]=1: pc_i <= stack_in_i.
  - instr[14]=1 and instr[15]=0: pc_i <= addr_cond_i[15:0], i.e. the zero-extended operand.
  - Otherwise pc_i <= pc_i + 1, wrapping 16'hFFFF to 16'h0000.
  - Branches are unconditional. The condition bit is exported only.
- Data write:
  - On a rising edge with instr_i[15]=1, bram[addr_i] <= acc_bit[i].
  - This includes RETURN instructions.
  - Reads in the same cycle return the old value; the new value is visible after the edge.
- Write collision: several cores writing the same bit in one edge → highest-numbered core wins.
- bram_clear=1 at a rising edge:
  - All bits are set to 0.
  - bram_clear overrides all stores in that cycle.
- Instruction memory writes:
  - prog_we=1 at a rising edge → imem[prog_addr] <= prog_data.
  - prog_addr >= IMEM_DEPTH is ignored.
  - The written word is readable on fetch from the next cycle.
  - imem_clear=1 zeroes all words and overrides prog_we.
- Program loading is done with reset held low, so PCs stay at their initial values.
- Reset deassertion is synchronised by the integrator. Mid-run reset returns all PCs to their initial values asynchronously.

Decomposition:
- Shared package holds:
  - instruction field constants: STORE_BIT=15, LOAD_BIT=14, ADDR_MSB=13
  - per-core PC init defaults
  - core count NUM_CORES=4
- One sub-module: fetch_pc, a single 16-bit PC with the next-PC mux, instantiated four times with PC_INITi.
- Both memories are arrays inside the top level.

Test Plan:
- Reset low then high, all-zero program, 3 clocks → pc = 3,6,9,12 for cores 0..3.
- imem[3]=16'h4020 (jump to 0x20), release reset → core1 pc=0x0020 after 1 clock; core0 pc=1.
- imem[0]=16'h8005, acc_bit[0]=1, one clock → bram[5]=1. Then imem[1]=16'h0005 → bit_data[0]=1 and addr_cond[16:0]=17'h10005.
- imem[6]=16'hC000, stack_in core2=16'h1234, one clock → core2 pc=16'h1234, and bram[0] <= acc_bit[2].
- Cores 0 and 3 both store to address 7 with acc_bit=4'b0001 → bram[7]=0 (core 3 wins). Repeat with bram_clear=1 → bram[7]=0 regardless of acc_bit.
- Mid-run async reset low between edges → pc returns to 0,3,6,9 before the next edge, and all bit_data read 0.

Source files
------------

// File: rtl/quad_core_fetch_mem_pkg.sv
// quad_core_fetch_mem_pkg
//   Shared definitions for the quad-core fetch/memory subsystem: instruction
//   field positions, decoded instruction layout, per-core reset PCs and the
//   core count.
package quad_core_fetch_mem_pkg;

   localparam int NUM_CORES = 4;
   localparam int PC_W      = 16;
   localparam int INSTR_W   = 16;

   // Instruction field positions
   localparam int STORE_BIT = 15;
   localparam int LOAD_BIT  = 14;
   localparam int ADDR_MSB  = 13;

   localparam logic [PC_W-1:0] PC_INIT0_DEF = 16'h0000;
   localparam logic [PC_W-1:0] PC_INIT1_DEF = 16'h0003;
   localparam logic [PC_W-1:0] PC_INIT2_DEF = 16'h0006;
   localparam logic [PC_W-1:0] PC_INIT3_DEF = 16'h0009;

   // Control field {STORE, LOAD_PC}; STORE alone does not affect the PC.
   typedef enum logic [1:0] {
      OP_NEXT   = 2'b00,
      OP_JUMP   = 2'b01,
      OP_STORE  = 2'b10,
      OP_RETURN = 2'b11
   } op_e;

   typedef struct packed {
      logic              store;
      logic              load_pc;
      logic [ADDR_MSB:0] addr;
   } instr_t;

   // Jump target: operand address zero-extended to PC width.
   function automatic logic [PC_W-1:0] operand_ext(input instr_t ins);
      return {{(PC_W-ADDR_MSB-1){1'b0}}, ins.addr};
   endfunction

endpackage

// File: rtl/quad_core_fetch_mem_fetch_pc.sv
// fetch_pc
//   One core's 16-bit program counter with its next-PC selection.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset, loads PC_INIT
//     instr      instruction currently fetched at pc
//     stack_val  return address used by RETURN
//     pc         current program counter
module fetch_pc
   import quad_core_fetch_mem_pkg::*;
#(
   parameter logic [PC_W-1:0] PC_INIT = 16'h0000
) (
   input  logic            clk,
   input  logic            reset,
   input  instr_t          instr,
   input  logic [PC_W-1:0] stack_val,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_next;

   // Branches are unconditional; the data bit is only exported upstream.
   always_comb begin
      pc_next = pc + 16'd1;
      case (op_e'({instr.store, instr.load_pc}))
         OP_RETURN: pc_next = stack_val;
         OP_JUMP:   pc_next = operand_ext(instr);
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc <= PC_INIT;
      else        pc <= pc_next;
   end

endmodule

// File: rtl/quad_core_fetch_mem.sv
// quad_core_fetch_mem
//   Shared fetch/memory subsystem of the 4-core bit-serial processor: four
//   PCs, a 4-read-port instruction memory and a 4-port 1-bit data RAM.
//   Ports:
//     clk, reset            clock, async active-low reset (PCs + data RAM)
//     prog_we/addr/data     instruction memory write port (loader)
//     imem_clear            sync clear of instruction memory, beats prog_we
//     bram_clear            sync clear of data RAM, beats all stores
//     acc_bit[i]            bit stored by core i on STORE
//     stack_in[16i+:16]     return address of core i
//     pc/instr[16i+:16]     PC and fetched instruction of core i
//     bit_data[i]           data RAM bit addressed by core i's operand
//     addr_cond[17i+:17]    {bit_data, 2'b00, operand} of core i
module quad_core_fetch_mem
   import quad_core_fetch_mem_pkg::*;
#(
   parameter logic [15:0] PC_INIT0   = PC_INIT0_DEF,
   parameter logic [15:0] PC_INIT1   = PC_INIT1_DEF,
   parameter logic [15:0] PC_INIT2   = PC_INIT2_DEF,
   parameter logic [15:0] PC_INIT3   = PC_INIT3_DEF,
   parameter int          IMEM_DEPTH = 256,
   parameter int          BRAM_DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     prog_we,
   input  logic [15:0]              prog_addr,
   input  logic [15:0]              prog_data,
   input  logic                     imem_clear,
   input  logic                     bram_clear,
   input  logic [NUM_CORES-1:0]     acc_bit,
   input  logic [NUM_CORES*16-1:0]  stack_in,
   output logic [NUM_CORES*16-1:0]  pc,
   output logic [NUM_CORES*16-1:0]  instr,
   output logic [NUM_CORES-1:0]     bit_data,
   output logic [NUM_CORES*17-1:0]  addr_cond
);

   localparam int IMEM_AW = $clog2(IMEM_DEPTH);
   localparam int BRAM_AW = $clog2(BRAM_DEPTH);

   localparam logic [NUM_CORES-1:0][PC_W-1:0] PC_INITS =
      {PC_INIT3, PC_INIT2, PC_INIT1, PC_INIT0};

   logic [INSTR_W-1:0]    imem [IMEM_DEPTH];
   logic [BRAM_DEPTH-1:0] bram;

   logic [NUM_CORES-1:0][PC_W-1:0]    pc_a;
   logic [NUM_CORES-1:0][INSTR_W-1:0] instr_a;

   genvar g;
   generate
      for (g = 0; g < NUM_CORES; g++) begin : g_core
         // PCs beyond the memory fetch a NOP-like zero word.
         assign instr_a[g] = ({16'd0, pc_a[g]} < 32'(IMEM_DEPTH))
                             ? imem[pc_a[g][IMEM_AW-1:0]] : '0;

         // Operand is taken modulo the data RAM depth.
         assign bit_data[g] = bram[instr_a[g][BRAM_AW-1:0]];

         assign addr_cond[17*g +: 17] = {bit_data[g], 2'b00, instr_a[g][ADDR_MSB:0]};
         assign pc[16*g +: 16]        = pc_a[g];
         assign instr[16*g +: 16]     = instr_a[g];

         fetch_pc #(
            .PC_INIT (PC_INITS[g])
         ) u_pc (
            .clk       (clk),
            .reset     (reset),
            .instr     (instr_t'(instr_a[g])),
            .stack_val (stack_in[16*g +: 16]),
            .pc        (pc_a[g])
         );
      end
   endgenerate

   // Instruction memory is untouched by reset so the loader can fill it
   // while the cores are held.
   always_ff @(posedge clk) begin
      if (imem_clear) begin
         for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
      end else if (prog_we && ({16'd0, prog_addr} < 32'(IMEM_DEPTH))) begin
         imem[prog_addr[IMEM_AW-1:0]] <= prog_data;
      end
   end

   // Stores are applied in ascending core order so the highest-numbered
   // core wins on a same-address collision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bram <= '0;
      end else if (bram_clear) begin
         bram <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (instr_a[i][STORE_BIT]) bram[instr_a[i][BRAM_AW-1:0]] <= acc_bit[i];
         end
      end
   end

endmodule

// File: tb/tb_quad_core_fetch_mem.sv
module tb_quad_core_fetch_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [15:0] prog_addr;
   logic [15:0] prog_data;
   logic        imem_clear;
   logic        bram_clear;
   logic [3:0]  acc_bit;
   logic [63:0] stack_in;
   logic [63:0] pc;
   logic [63:0] instr;
   logic [3:0]  bit_data;
   logic [67:0] addr_cond;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   quad_core_fetch_mem dut (
      .clk        (clk),
      .reset      (reset),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .imem_clear (imem_clear),
      .bram_clear (bram_clear),
      .acc_bit    (acc_bit),
      .stack_in   (stack_in),
      .pc         (pc),
      .instr      (instr),
      .bit_data   (bit_data),
      .addr_cond  (addr_cond)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_imem [256];
   logic        m_bram [64];
   logic [15:0] m_pc   [4];
   localparam logic [15:0] INIT_PC [4] = '{16'h0000, 16'h0003, 16'h0006, 16'h0009};

   function automatic logic [15:0] m_fetch(input logic [15:0] p);
      if (p < 16'd256) return m_imem[p[7:0]];
      return 16'h0000;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_pc[i] = INIT_PC[i];
      for (int i = 0; i < 64; i++) m_bram[i] = 1'b0;
   endtask

   // Applies one rising edge to the model using the inputs present at it.
   task automatic model_edge();
      logic [15:0] ins [4];
      for (int i = 0; i < 4; i++) ins[i] = m_fetch(m_pc[i]);
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            if (ins[i][15] && ins[i][14]) m_pc[i] = stack_in[16*i +: 16];
            else if (ins[i][14])          m_pc[i] = {2'b00, ins[i][13:0]};
            else                          m_pc[i] = m_pc[i] + 16'd1;
         end
         if (bram_clear) begin
            for (int a = 0; a < 64; a++) m_bram[a] = 1'b0;
         end else begin
            for (int i = 0; i < 4; i++)
               if (ins[i][15]) m_bram[ins[i][13:0] % 64] = acc_bit[i];
         end
      end
      if (imem_clear) begin
         for (int a = 0; a < 256; a++) m_imem[a] = 16'h0000;
      end else if (prog_we && prog_addr < 16'd256) begin
         m_imem[prog_addr[7:0]] = prog_data;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [63:0] e_pc, e_instr;
      logic [3:0]  e_bit;
      logic [67:0] e_ac;
      logic [15:0] ins;
      for (int i = 0; i < 4; i++) begin
         ins = m_fetch(m_pc[i]);
         e_pc[16*i +: 16]    = m_pc[i];
         e_instr[16*i +: 16] = ins;
         e_bit[i]            = m_bram[ins[13:0] % 64];
         e_ac[17*i +: 17]    = {e_bit[i], 2'b00, ins[13:0]};
      end
      chk("cmp_pc",        {4'h0, pc},         {4'h0, e_pc});
      chk("cmp_instr",     {4'h0, instr},      {4'h0, e_instr});
      chk("cmp_bit_data",  {64'h0, bit_data},  {64'h0, e_bit});
      chk("cmp_addr_cond", addr_cond,          e_ac);
   endtask

   always @(negedge clk) if (chk_en) check_all();

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic go_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      imem_clear = 1'b0; bram_clear = 1'b0; acc_bit = '0; stack_in = '0;
      model_reset();
      #2;
      // Clear instruction memory while held in reset
      imem_clear = 1'b1; tick(); imem_clear = 1'b0;
      chk_en = 1'b1;
      chk("reset_pc",   {4'h0, pc},        {4'h0, 64'h0009_0006_0003_0000});
      chk("reset_bits", {64'h0, bit_data}, 68'h0);

      // All-zero program, three clocks
      reset = 1'b1;
      tick(); tick(); tick();
      chk("zero_prog_pc", {4'h0, pc}, {4'h0, 64'h000C_0009_0006_0003});

      // Jump on core 1; out-of-range program write must be ignored
      go_reset();
      load(16'h0003, 16'h4020);
      load(16'h0100, 16'hFFFF);
      reset = 1'b1;
      tick();
      chk("jump_core1", {52'h0, pc[31:16]}, 68'h0020);
      chk("jump_core0", {52'h0, pc[15:0]},  68'h0001);

      // Store then load on core 0
      go_reset();
      load(16'h0000, 16'h8005);
      load(16'h0001, 16'h0005);
      acc_bit = 4'b0001;
      reset = 1'b1;
      tick();
      chk("store_bit0", {67'h0, bit_data[0]},   68'h1);
      chk("store_ac0",  {51'h0, addr_cond[16:0]}, 68'h10005);

      // RETURN on core 2 also stores acc_bit[2] to bram[0]
      go_reset();
      load(16'h0006, 16'hC000);
      stack_in[47:32] = 16'h1234;
      acc_bit = 4'b0100;
      reset = 1'b1;
      tick();
      chk("ret_pc2",  {52'h0, pc[47:32]}, 68'h1234);
      chk("ret_bits", {64'h0, bit_data},  68'hE);

      // PC wrap from FFFF to 0000
      go_reset();
      stack_in[47:32] = 16'hFFFF;
      reset = 1'b1;
      tick();
      chk("wrap_pre",  {52'h0, pc[47:32]}, 68'hFFFF);
      tick();
      chk("wrap_post", {52'h0, pc[47:32]}, 68'h0000);

      // Collision: cores 0 and 3 store to address 7; imem_clear beats prog_we
      go_reset();
      prog_we = 1'b1; prog_addr = 16'h0002; prog_data = 16'h4444; imem_clear = 1'b1;
      tick();
      prog_we = 1'b0; imem_clear = 1'b0;
      load(16'h0000, 16'h8007);
      load(16'h0009, 16'h8007);
      load(16'h0001, 16'h0007);
      load(16'h000A, 16'h0007);
      acc_bit = 4'b0001;
      reset = 1'b1;
      tick();
      chk("coll_core3_zero", {64'h0, bit_data}, 68'h0);

      go_reset();
      acc_bit = 4'b1000;
      reset = 1'b1;
      tick();
      chk("coll_core3_one", {64'h0, bit_data}, 68'h9);

      go_reset();
      acc_bit = 4'b1001;
      bram_clear = 1'b1;
      reset = 1'b1;
      tick();
      bram_clear = 1'b0;
      chk("bram_clear", {64'h0, bit_data}, 68'h0);

      // Mid-run asynchronous reset between edges
      go_reset();
      acc_bit = 4'b1000;
      reset = 1'b1;
      tick();
      chk("pre_async_bits", {64'h0, bit_data}, 68'h9);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_pc",   {4'h0, pc},        {4'h0, 64'h0009_0006_0003_0000});
      chk("async_bits", {64'h0, bit_data}, 68'h0);
      tick(); tick();
      chk("held_pc", {4'h0, pc}, {4'h0, 64'h0009_0006_0003_0000});

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
